// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared SoC constants: IO page bit, UART register map, STATUS bits, UART FSM encoding
package soc_pkg;

  localparam int IO_BIT = 22;

  localparam logic [1:0] UART_DATA_OFS   = 2'd0;
  localparam logic [1:0] UART_STATUS_OFS = 2'd1;

  localparam int STAT_FULL_BIT    = 0;
  localparam int STAT_BUSY_BIT    = 1;
  localparam int STAT_OVERRUN_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // A one-cycle bit still needs a 1-bit counter so the wrap compare is well formed.
  function automatic int baud_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy counter and modulo-DEPTH pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with DATA/STATUS registers
// Optional 4-entry transmit FIFO enabled by MMIO_UART_TX_FIFO_EN.
module mmio_uart_tx #(
  parameter int XLEN         = 32,
  parameter int IO_BIT       = soc_pkg::IO_BIT,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [3:0]      mem_wmask,
  input  logic            mem_rstrb,
  output logic [XLEN-1:0] mem_rdata,
  output logic            io_sel,
  output logic            uart_tx
);

  import soc_pkg::*;

  localparam int              BAUD_W   = baud_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state;
  uart_state_e       state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              overrun;

  logic [1:0] reg_ofs;
  logic       wr_req;
  logic       rd_req;
  logic       rd_status;
  logic       q_full;
  logic       busy;
  logic       wr_ok;
  logic       overrun_set;
  logic       bit_tick;
  logic       need_byte;
  logic       byte_avail;
  logic       load;
  logic [7:0] load_data;
  logic [2:0] status;
  logic       unused_bits;

  assign io_sel    = mem_addr[IO_BIT];
  assign reg_ofs   = mem_addr[3:2];
  assign wr_req    = io_sel && (reg_ofs == UART_DATA_OFS) && mem_wmask[0];
  assign rd_req    = mem_rstrb && io_sel;
  assign rd_status = rd_req && (reg_ofs == UART_STATUS_OFS);

  assign unused_bits = ^{mem_addr, mem_wdata[XLEN-1:8], mem_wmask[3:1]};

  assign bit_tick  = (state != ST_IDLE) && (baud_cnt == BAUD_MAX);
  // A new byte can be taken while idle or exactly at the end of a stop bit.
  assign need_byte = (state == ST_IDLE) || ((state == ST_STOP) && bit_tick);

`ifdef MMIO_UART_TX_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_dout;

  assign q_full     = fifo_full;
  assign wr_ok      = wr_req && !q_full;
  assign byte_avail = !fifo_empty || wr_ok;
  assign load       = need_byte && byte_avail;
  // An empty queue is bypassed so a write to an idle block starts on the next cycle.
  assign load_data  = fifo_empty ? mem_wdata[7:0] : fifo_dout;
  assign fifo_push  = wr_ok && !(load && fifo_empty);
  assign fifo_pop   = load && !fifo_empty;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(4)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (fifo_push),
    .push_data(mem_wdata[7:0]),
    .pop      (fifo_pop),
    .pop_data (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
`else
  assign q_full     = (state != ST_IDLE);
  assign wr_ok      = wr_req && !q_full;
  assign byte_avail = wr_ok;
  assign load       = need_byte && byte_avail;
  assign load_data  = mem_wdata[7:0];
  assign busy       = q_full;
`endif

  assign overrun_set = wr_req && q_full;

  always_comb begin
    status                   = 3'b000;
    status[STAT_FULL_BIT]    = q_full;
    status[STAT_BUSY_BIT]    = busy;
    status[STAT_OVERRUN_BIT] = overrun;
  end

  always_comb begin
    state_d = state;
    uart_tx = 1'b1;
    case (state)
      ST_IDLE: begin
        if (load) state_d = ST_START;
      end
      ST_START: begin
        uart_tx = 1'b0;
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        uart_tx = shift_reg[0];
        if (bit_tick && (bit_cnt == 3'd7)) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) state_d = load ? ST_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      overrun   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if ((state == ST_IDLE) || bit_tick) baud_cnt <= '0;
      else                                baud_cnt <= baud_cnt + 1'b1;

      if (load)                                shift_reg <= load_data;
      else if ((state == ST_DATA) && bit_tick) shift_reg <= {1'b0, shift_reg[7:1]};

      if (state == ST_START)                   bit_cnt <= 3'd0;
      else if ((state == ST_DATA) && bit_tick) bit_cnt <= bit_cnt + 3'd1;

      // Set wins over the clear-on-read.
      overrun <= overrun_set | (overrun & ~rd_status);

      if (mem_rstrb) mem_rdata <= rd_status ? {{(XLEN-3){1'b0}}, status} : '0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT = 4)
module tb_mmio_uart_tx;

  localparam logic [31:0] IO_BASE  = 32'h0040_0000;
  localparam logic [31:0] STAT_ADR = IO_BASE | 32'h4;

`ifdef MMIO_UART_TX_FIFO_EN
  localparam int          OVR_WRITES = 6;
  localparam int          OVR_SENT   = 5;
  localparam int          B2B_N      = 3;
  localparam logic [31:0] STAT_RUN   = 32'h2;
`else
  localparam int          OVR_WRITES = 2;
  localparam int          OVR_SENT   = 1;
  localparam int          B2B_N      = 1;
  localparam logic [31:0] STAT_RUN   = 32'h3;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        io_sel;
  logic        uart_tx;

  int tests = 0;
  int fails = 0;

  mmio_uart_tx #(
    .XLEN(32),
    .IO_BIT(22),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata),
    .io_sel   (io_sel),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [7:0] b, input logic [3:0] mask);
    mem_addr  = addr;
    mem_wdata = {24'hABCDEF, b};
    mem_wmask = mask;
    mem_rstrb = 1'b0;
  endtask

  task automatic drive_read(input logic [31:0] addr);
    mem_addr  = addr;
    mem_wdata = 32'h0;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b1;
  endtask

  // Line level for frame cycle index idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic read_status_expect(input string tag, input logic [31:0] exp);
    bus_idle();
    drive_read(STAT_ADR);
    step();
    bus_idle();
    check32(tag, mem_rdata, exp);
  endtask

  // Writes n bytes on consecutive cycles and checks every cycle of the resulting frames.
  task automatic send_check(input logic [23:0] bytes, input int n, input string tag);
    bus_idle();
    drive_write(IO_BASE, bytes[7:0], 4'hF);
    step();
    for (int k = 0; k < n * 40; k++) begin
      if (k == 6) check32({tag, "_stat_run"}, mem_rdata, STAT_RUN);
      check_bit({tag, "_tx"}, uart_tx, frame_bit(bytes[8*(k/40) +: 8], (k % 40) / 4));
      bus_idle();
      if (k + 1 < n) drive_write(IO_BASE, bytes[8*(k+1) +: 8], 4'hF);
      else if (k == 5 || k == n * 40 - 1) drive_read(STAT_ADR);
      step();
    end
    check32({tag, "_stat_last"}, mem_rdata, STAT_RUN);
    check_bit({tag, "_idle_tx"}, uart_tx, 1'b1);
    read_status_expect({tag, "_stat_done"}, 32'h0);
  endtask

  initial begin
    bus_idle();
    resetn = 1'b0;
    repeat (3) step();
    check_bit("rst_tx", uart_tx, 1'b1);
    check32("rst_rdata", mem_rdata, 32'h0);
    resetn = 1'b1;
    step();
    mem_addr = STAT_ADR;
    #1;
    check_bit("io_sel_io", io_sel, 1'b1);
    read_status_expect("rst_status", 32'h0);

    // Writes that must not reach the shifter.
    drive_write(IO_BASE | 32'h8, 8'h55, 4'hF);
    step();
    check_bit("ign_ofs2_tx", uart_tx, 1'b1);
    drive_write(IO_BASE, 8'h55, 4'b1110);
    step();
    check_bit("ign_mask_tx", uart_tx, 1'b1);
    drive_write(32'h0, 8'h55, 4'hF);
    step();
    check_bit("ign_ram_io_sel", io_sel, 1'b0);
    check_bit("ign_ram_tx", uart_tx, 1'b1);
    read_status_expect("ign_status", 32'h0);

    send_check(24'h0000A5, 1, "single");
    send_check(24'h030201, B2B_N, "b2b");

    // Overrun: one byte beyond capacity is dropped; STATUS read clears the sticky bit.
    bus_idle();
    drive_write(IO_BASE, 8'h10, 4'hF);
    step();
    for (int k = 0; k < OVR_SENT * 40; k++) begin
      if (k == OVR_WRITES - 1) check32("ovr_rd_before", mem_rdata, 32'h0);
      if (k == OVR_WRITES)     check32("ovr_status", mem_rdata, 32'h7);
      if (k == OVR_WRITES + 1) check32("ovr_cleared", mem_rdata, 32'h3);
      if (k == OVR_WRITES + 2) begin
        check_bit("ram_io_sel", io_sel, 1'b0);
        check32("ram_rdata", mem_rdata, 32'h0);
      end
      check_bit("ovr_tx", uart_tx, frame_bit(8'h10 + 8'(k / 40), (k % 40) / 4));
      bus_idle();
      if (k < OVR_WRITES - 1) drive_write(IO_BASE, 8'h10 + 8'(k + 1), 4'hF);
      else if (k == OVR_WRITES - 1 || k == OVR_WRITES) drive_read(STAT_ADR);
      else if (k == OVR_WRITES + 1) drive_read(32'h0000_0004);
      step();
    end
    check_bit("ovr_idle_tx", uart_tx, 1'b1);
    read_status_expect("ovr_done", 32'h0);

    // Reset during data bit 3 of 0xF0 (line low there) with further bytes pending.
    drive_write(IO_BASE, 8'hF0, 4'hF);
    step();
    drive_write(IO_BASE, 8'h11, 4'hF);
    step();
    drive_write(IO_BASE, 8'h22, 4'hF);
    step();
    bus_idle();
    repeat (15) step();
    check_bit("mid_pre_tx", uart_tx, 1'b0);
    #1 resetn = 1'b0;
    #1 check_bit("mid_async_tx", uart_tx, 1'b1);
    step();
    step();
    resetn = 1'b1;
    check32("mid_rdata", mem_rdata, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_bit("mid_idle_tx", uart_tx, 1'b1);
    end
    read_status_expect("mid_status", 32'h0);
    send_check(24'h00005A, 1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
